// File: rtl/mips_isa_pkg.sv
// MIPS opcode/funct map, op_sel encoding and field positions shared by the
// instruction encoder and the core's decoder.
package mips_isa_pkg;

  localparam int unsigned OPC_LSB   = 26;
  localparam int unsigned RS_LSB    = 21;
  localparam int unsigned RT_LSB    = 16;
  localparam int unsigned RD_LSB    = 11;
  localparam int unsigned SHAMT_LSB = 6;

  localparam logic [5:0] OPC_SPECIAL = 6'h00;
  localparam logic [5:0] OPC_J       = 6'h02;
  localparam logic [5:0] OPC_JAL     = 6'h03;
  localparam logic [5:0] OPC_BEQ     = 6'h04;
  localparam logic [5:0] OPC_BNE     = 6'h05;
  localparam logic [5:0] OPC_ADDI    = 6'h08;
  localparam logic [5:0] OPC_SLTI    = 6'h0A;
  localparam logic [5:0] OPC_ANDI    = 6'h0C;
  localparam logic [5:0] OPC_ORI     = 6'h0D;
  localparam logic [5:0] OPC_LUI     = 6'h0F;
  localparam logic [5:0] OPC_LW      = 6'h23;
  localparam logic [5:0] OPC_SW      = 6'h2B;

  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_JR   = 6'h08;
  localparam logic [5:0] FUNCT_MFLO = 6'h12;
  localparam logic [5:0] FUNCT_MULT = 6'h18;
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_OR   = 6'h25;

  typedef enum logic [4:0] {
    OP_SLL, OP_JR, OP_MFLO, OP_MULT, OP_ADD, OP_OR, OP_J, OP_JAL, OP_BEQ,
    OP_BNE, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW
  } op_sel_e;

  function automatic logic [31:0] r_word(input logic [5:0] funct, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [4:0] shamt);
    return (32'(OPC_SPECIAL) << OPC_LSB) | (32'(rs) << RS_LSB) | (32'(rt) << RT_LSB) |
           (32'(rd) << RD_LSB) | (32'(shamt) << SHAMT_LSB) | 32'(funct);
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] opc, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return (32'(opc) << OPC_LSB) | (32'(rs) << RS_LSB) | (32'(rt) << RT_LSB) | 32'(imm);
  endfunction

  function automatic logic [31:0] j_word(input logic [5:0] opc, input logic [25:0] target);
    return (32'(opc) << OPC_LSB) | 32'(target);
  endfunction

endpackage

// File: rtl/mips_word_packer.sv
// Combinational op_sel + field to 32-bit MIPS word mapping; unused fields are
// forced to zero and op_sel values outside the subset clear 'supported'.
module mips_word_packer
  import mips_isa_pkg::*;
(
  input  logic [4:0]  op_sel,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        supported
);

  always_comb begin
    word      = '0;
    supported = 1'b1;
    case (op_sel)
      OP_SLL:  word = r_word(FUNCT_SLL,  5'd0, rt,   rd,   shamt);
      OP_JR:   word = r_word(FUNCT_JR,   rs,   5'd0, 5'd0, 5'd0);
      OP_MFLO: word = r_word(FUNCT_MFLO, 5'd0, 5'd0, rd,   5'd0);
      OP_MULT: word = r_word(FUNCT_MULT, rs,   rt,   5'd0, 5'd0);
      OP_ADD:  word = r_word(FUNCT_ADD,  rs,   rt,   rd,   5'd0);
      OP_OR:   word = r_word(FUNCT_OR,   rs,   rt,   rd,   5'd0);
      OP_J:    word = j_word(OPC_J,   target);
      OP_JAL:  word = j_word(OPC_JAL, target);
      OP_BEQ:  word = i_word(OPC_BEQ,  rs, rt, imm);
      OP_BNE:  word = i_word(OPC_BNE,  rs, rt, imm);
      OP_ADDI: word = i_word(OPC_ADDI, rs, rt, imm);
      OP_SLTI: word = i_word(OPC_SLTI, rs, rt, imm);
      OP_ANDI: word = i_word(OPC_ANDI, rs, rt, imm);
      OP_ORI:  word = i_word(OPC_ORI,  rs, rt, imm);
      OP_LUI:  word = i_word(OPC_LUI,  5'd0, rt, imm);
      OP_LW:   word = i_word(OPC_LW,   rs, rt, imm);
      OP_SW:   word = i_word(OPC_SW,   rs, rt, imm);
      default: supported = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// Sequential instruction-memory writer: accepts symbolic requests, writes
// encoded words at an incrementing address. MIPS_INSTR_ENCODER_READBACK_EN adds read-verify.
module mips_instr_encoder #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4:0]            op_sel,
  input  logic [4:0]            rs,
  input  logic [4:0]            rt,
  input  logic [4:0]            rd,
  input  logic [4:0]            shamt,
  input  logic [15:0]           imm,
  input  logic [25:0]           target,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ready,
`ifdef MIPS_INSTR_ENCODER_READBACK_EN
  output logic                  mem_re,
  input  logic [31:0]           mem_rdata,
  output logic                  verify_err,
`endif
  output logic [ADDR_WIDTH:0]   instr_count,
  output logic                  prog_full,
  output logic                  err_unsupported
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
`ifdef MIPS_INSTR_ENCODER_READBACK_EN
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_CHECK = 2'd3;
`endif

  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           word_q, word_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  full_q, full_d;
  logic                  err_q, err_d;
  logic                  advance;
  logic [31:0]           pk_word;
  logic                  pk_supported;
`ifdef MIPS_INSTR_ENCODER_READBACK_EN
  logic                  verr_q, verr_d;
`endif

  mips_word_packer u_packer (
    .op_sel    (op_sel),
    .rs        (rs),
    .rt        (rt),
    .rd        (rd),
    .shamt     (shamt),
    .imm       (imm),
    .target    (target),
    .word      (pk_word),
    .supported (pk_supported)
  );

  assign in_ready        = (state_q == ST_IDLE) && !full_q;
  assign mem_we          = (state_q == ST_WRITE);
  assign mem_addr        = addr_q;
  assign mem_wdata       = word_q;
  assign instr_count     = count_q;
  assign prog_full       = full_q;
  assign err_unsupported = err_q;
`ifdef MIPS_INSTR_ENCODER_READBACK_EN
  assign mem_re          = (state_q == ST_READ);
  assign verify_err      = verr_q;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    word_d  = word_q;
    count_d = count_q;
    full_d  = full_q;
    err_d   = 1'b0;
    advance = 1'b0;
`ifdef MIPS_INSTR_ENCODER_READBACK_EN
    verr_d  = verr_q;
`endif
    if (clear) begin
      state_d = ST_IDLE;
      addr_d  = BASE;
      count_d = '0;
      full_d  = 1'b0;
`ifdef MIPS_INSTR_ENCODER_READBACK_EN
      verr_d  = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            if (pk_supported) begin
              word_d  = pk_word;
              state_d = ST_WRITE;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        ST_WRITE: begin
          if (mem_ready) begin
`ifdef MIPS_INSTR_ENCODER_READBACK_EN
            state_d = ST_READ;
`else
            advance = 1'b1;
            state_d = ST_IDLE;
`endif
          end
        end
`ifdef MIPS_INSTR_ENCODER_READBACK_EN
        ST_READ:  state_d = ST_CHECK;
        ST_CHECK: begin
          if (mem_rdata != word_q) verr_d = 1'b1;
          advance = 1'b1;
          state_d = ST_IDLE;
        end
`endif
        default: state_d = ST_IDLE;
      endcase
      // The pointer saturates on the last address; prog_full then blocks accepts.
      if (advance) begin
        count_d = count_q + 1'b1;
        if (addr_q == LAST) full_d = 1'b1;
        else                addr_d = addr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      addr_q  <= BASE;
      word_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef MIPS_INSTR_ENCODER_READBACK_EN
      verr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      count_q <= count_d;
      full_q  <= full_d;
      err_q   <= err_d;
`ifdef MIPS_INSTR_ENCODER_READBACK_EN
      verr_q  <= verr_d;
`endif
    end
  end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Directed + randomised bench for mips_instr_encoder (ADDR_WIDTH=2) with an
// expected-write scoreboard; readback checks when MIPS_INSTR_ENCODER_READBACK_EN is set.
module tb_mips_instr_encoder;

  localparam int unsigned AW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [4:0]    op_sel, rs, rt, rd, shamt;
  logic [15:0]   imm;
  logic [25:0]   target;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_ready;
  logic [AW:0]   instr_count;
  logic          prog_full;
  logic          err_unsupported;
`ifdef MIPS_INSTR_ENCODER_READBACK_EN
  logic          mem_re;
  logic [31:0]   mem_rdata;
  logic          verify_err;
  logic [31:0]   mem_img [4];
  logic          rd_zero;
`endif

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [AW-1:0] exp_addr;
  logic [AW:0]   exp_count;
  logic          exp_full;

  mips_instr_encoder #(.ADDR_WIDTH(AW), .BASE_ADDR(0)) dut (
    .clk             (clk),
    .reset           (reset),
    .clear           (clear),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .op_sel          (op_sel),
    .rs              (rs),
    .rt              (rt),
    .rd              (rd),
    .shamt           (shamt),
    .imm             (imm),
    .target          (target),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_ready       (mem_ready),
`ifdef MIPS_INSTR_ENCODER_READBACK_EN
    .mem_re          (mem_re),
    .mem_rdata       (mem_rdata),
    .verify_err      (verify_err),
`endif
    .instr_count     (instr_count),
    .prog_full       (prog_full),
    .err_unsupported (err_unsupported)
  );

  always #5 clk = ~clk;

`ifdef MIPS_INSTR_ENCODER_READBACK_EN
  always @(posedge clk) if (mem_we && mem_ready) mem_img[mem_addr] <= mem_wdata;
  assign mem_rdata = rd_zero ? 32'h0 : mem_img[mem_addr];
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference encoding written directly from the instruction formats.
  function automatic logic [32:0] model(input logic [4:0] op, input logic [4:0] a_rs,
                                        input logic [4:0] a_rt, input logic [4:0] a_rd,
                                        input logic [4:0] a_sh, input logic [15:0] a_imm,
                                        input logic [25:0] a_tgt);
    case (op)
      5'd0:  return {1'b1, 6'h00, 5'd0, a_rt, a_rd, a_sh, 6'h00};
      5'd1:  return {1'b1, 6'h00, a_rs, 15'd0, 6'h08};
      5'd2:  return {1'b1, 6'h00, 10'd0, a_rd, 5'd0, 6'h12};
      5'd3:  return {1'b1, 6'h00, a_rs, a_rt, 10'd0, 6'h18};
      5'd4:  return {1'b1, 6'h00, a_rs, a_rt, a_rd, 5'd0, 6'h20};
      5'd5:  return {1'b1, 6'h00, a_rs, a_rt, a_rd, 5'd0, 6'h25};
      5'd6:  return {1'b1, 6'h02, a_tgt};
      5'd7:  return {1'b1, 6'h03, a_tgt};
      5'd8:  return {1'b1, 6'h04, a_rs, a_rt, a_imm};
      5'd9:  return {1'b1, 6'h05, a_rs, a_rt, a_imm};
      5'd10: return {1'b1, 6'h08, a_rs, a_rt, a_imm};
      5'd11: return {1'b1, 6'h0A, a_rs, a_rt, a_imm};
      5'd12: return {1'b1, 6'h0C, a_rs, a_rt, a_imm};
      5'd13: return {1'b1, 6'h0D, a_rs, a_rt, a_imm};
      5'd14: return {1'b1, 6'h0F, 5'd0, a_rt, a_imm};
      5'd15: return {1'b1, 6'h23, a_rs, a_rt, a_imm};
      5'd16: return {1'b1, 6'h2B, a_rs, a_rt, a_imm};
      default: return 33'd0;
    endcase
  endfunction

  // Present one request and return at the negedge after the accepting edge.
  task automatic send(input logic [4:0] op, input logic [4:0] a_rs, input logic [4:0] a_rt,
                      input logic [4:0] a_rd, input logic [4:0] a_sh, input logic [15:0] a_imm,
                      input logic [25:0] a_tgt, input logic exp_ok, input logic [31:0] exp_word);
    exp_t e;
    int   n;
    @(negedge clk);
    op_sel = op; rs = a_rs; rt = a_rt; rd = a_rd; shamt = a_sh; imm = a_imm; target = a_tgt;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", 32'(in_ready), 32'd1);
    if (exp_ok) begin
      e.addr = exp_addr;
      e.data = exp_word;
      sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    op_sel = 5'($urandom); rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
    shamt = 5'($urandom); imm = 16'($urandom); target = 26'($urandom);
  endtask

  // Complete the pending write, stalling mem_ready for 'hold' cycles.
  task automatic drain(input int hold);
    exp_t e;
    int   n;
    n = 0;
    while (!mem_we && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("we_rise", 32'(mem_we), 32'd1);
    if (sb.size() > 0) e = sb.pop_front();
    else               e = '1;
    chk("wr_addr", 32'(mem_addr), 32'(e.addr));
    chk("wr_data", mem_wdata, e.data);
    for (int i = 0; i < hold; i++) begin
      chk("stall_we", 32'(mem_we), 32'd1);
      chk("stall_addr", 32'(mem_addr), 32'(e.addr));
      chk("stall_data", mem_wdata, e.data);
      chk("stall_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    exp_count = exp_count + 1'b1;
    if (exp_addr == AW'(3)) exp_full = 1'b1;
    else                    exp_addr = exp_addr + 1'b1;
`ifdef MIPS_INSTR_ENCODER_READBACK_EN
    chk("rb_re", 32'(mem_re), 32'd1);
    chk("rb_re_addr", 32'(mem_addr), 32'(e.addr));
    @(negedge clk);
    @(negedge clk);
`endif
    chk("lat_we", 32'(mem_we), 32'd0);
    chk("lat_ready", 32'(in_ready), 32'(!exp_full));
    chk("count", 32'(instr_count), 32'(exp_count));
    chk("full", 32'(prog_full), 32'(exp_full));
    chk("addr", 32'(mem_addr), 32'(exp_addr));
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    exp_addr = '0; exp_count = '0; exp_full = 1'b0;
    chk("clr_addr", 32'(mem_addr), 32'd0);
    chk("clr_count", 32'(instr_count), 32'd0);
    chk("clr_full", 32'(prog_full), 32'd0);
    chk("clr_ready", 32'(in_ready), 32'd1);
    chk("clr_we", 32'(mem_we), 32'd0);
`ifdef MIPS_INSTR_ENCODER_READBACK_EN
    chk("clr_verr", 32'(verify_err), 32'd0);
`endif
  endtask

  initial begin
    logic [32:0] m;
    logic [4:0]  op;
    logic [4:0]  f_rs, f_rt, f_rd, f_sh;
    logic [15:0] f_imm;
    logic [25:0] f_tgt;

    reset = 1'b0; clear = 1'b0; in_valid = 1'b0; mem_ready = 1'b0;
    op_sel = '0; rs = '0; rt = '0; rd = '0; shamt = '0; imm = '0; target = '0;
    exp_addr = '0; exp_count = '0; exp_full = 1'b0;
`ifdef MIPS_INSTR_ENCODER_READBACK_EN
    rd_zero = 1'b0;
`endif
    #1;
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_count", 32'(instr_count), 32'd0);
    chk("rst_full", 32'(prog_full), 32'd0);
    chk("rst_err", 32'(err_unsupported), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // add $8,$9,$10
    send(5'd4, 5'd9, 5'd10, 5'd8, 5'd0, 16'h0, 26'h0, 1'b1, 32'h012A4020);
    drain(0);

    // addi $8,$0,5 then j 0x0100000
    do_clear();
    send(5'd10, 5'd0, 5'd8, 5'd0, 5'd0, 16'h0005, 26'h0, 1'b1, 32'h20080005);
    drain(0);
    send(5'd6, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0100000, 1'b1, 32'h08100000);
    drain(0);

    // lui $1,0x1001 with junk rs and a 3-cycle memory stall
    send(5'd14, 5'd7, 5'd1, 5'd0, 5'd0, 16'h1001, 26'h0, 1'b1, 32'h3C011001);
    drain(3);
`ifdef MIPS_INSTR_ENCODER_READBACK_EN
    chk("verr_clean", 32'(verify_err), 32'd0);
`endif

    // unsupported op_sel
    send(5'd20, 5'd1, 5'd2, 5'd3, 5'd4, 16'h1234, 26'h0, 1'b0, 32'h0);
    chk("unsup_err", 32'(err_unsupported), 32'd1);
    chk("unsup_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    chk("unsup_pulse", 32'(err_unsupported), 32'd0);
    chk("unsup_count", 32'(instr_count), 32'(exp_count));
    chk("unsup_ready", 32'(in_ready), 32'd1);

    // fill the last address, then requests must be refused
    send(5'd5, 5'd3, 5'd4, 5'd5, 5'd9, 16'h0, 26'h0, 1'b1, 32'h00642825);
    drain(0);
    @(negedge clk);
    in_valid = 1'b1; op_sel = 5'd4;
    repeat (3) begin
      @(negedge clk);
      chk("full_we", 32'(mem_we), 32'd0);
      chk("full_ready", 32'(in_ready), 32'd0);
      chk("full_addr", 32'(mem_addr), 32'd3);
      chk("full_count", 32'(instr_count), 32'd4);
    end
    in_valid = 1'b0;
    do_clear();

    // request in the same cycle as clear is dropped
    @(negedge clk);
    clear = 1'b1; in_valid = 1'b1; op_sel = 5'd4;
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
    chk("clr_req_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    chk("clr_req_we2", 32'(mem_we), 32'd0);
    chk("clr_req_count", 32'(instr_count), 32'd0);

    // clear abandons an in-flight write
    send(5'd4, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1, 32'h00221820);
    chk("inflight_we", 32'(mem_we), 32'd1);
    void'(sb.pop_back());
    do_clear();

    // randomised sweep of every op_sel
    for (int i = 0; i < 24; i++) begin
      op    = (i < 17) ? 5'(i) : 5'($urandom_range(17, 31));
      f_rs  = 5'($urandom); f_rt = 5'($urandom); f_rd = 5'($urandom); f_sh = 5'($urandom);
      f_imm = 16'($urandom); f_tgt = 26'($urandom);
      m = model(op, f_rs, f_rt, f_rd, f_sh, f_imm, f_tgt);
      if (exp_full) do_clear();
      send(op, f_rs, f_rt, f_rd, f_sh, f_imm, f_tgt, m[32], m[31:0]);
      if (m[32]) begin
        drain(i % 3);
      end else begin
        chk("rand_unsup_err", 32'(err_unsupported), 32'd1);
        chk("rand_unsup_we", 32'(mem_we), 32'd0);
      end
    end

    // asynchronous reset in the middle of a write
    if (exp_full) do_clear();
    send(5'd15, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0010, 26'h0, 1'b1, 32'h8FA80010);
    void'(sb.pop_back());
    chk("mid_we", 32'(mem_we), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_we", 32'(mem_we), 32'd0);
    chk("async_addr", 32'(mem_addr), 32'd0);
    chk("async_count", 32'(instr_count), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    exp_addr = '0; exp_count = '0; exp_full = 1'b0;

`ifdef MIPS_INSTR_ENCODER_READBACK_EN
    rd_zero = 1'b1;
    send(5'd16, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0, 1'b1, 32'hAFA80004);
    drain(0);
    chk("verify_err", 32'(verify_err), 32'd1);
    rd_zero = 1'b0;
`else
    send(5'd16, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0, 1'b1, 32'hAFA80004);
    drain(0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
